// File: rtl/alu_seq.sv
// Round-robin scheduler and sequencer in front of a shared 16-bit ALU.
// 8/16-bit ops take one ALU pass; 32-bit ops take a low pass, then a carry-linked high pass.
module alu_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_mode,
    input  logic [1:0]  req0_size,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_mode,
    input  logic [1:0]  req1_size,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    input  logic [11:0] flags_in,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [11:0] rsp_flags,
    output logic        alu_isize,
    output logic [3:0]  alu_mode,
    output logic [15:0] alu_op1,
    output logic [15:0] alu_op2,
    output logic [11:0] alu_flags,
    input  logic [15:0] alu_result,
    input  logic [11:0] alu_flags_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, LO = 2'd1, HI = 2'd2, RESP = 2'd3} state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        id_q, id_d;
    logic [2:0]  mode_q, mode_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] op2_q, op2_d;
    logic [11:0] cflags_q, cflags_d;
    logic [11:0] lo_flags_q, lo_flags_d;
    logic [31:0] result_q, result_d;
    logic [11:0] rflags_q, rflags_d;

    logic        grant;
    logic        is_idle;
    logic        accept;
    logic [2:0]  hi_mode;

    // Handshake: a request transfers on a clock edge where valid and ready are both high.
    // Ready is offered only in IDLE and only to the requester that wins arbitration;
    // rsp_valid is a pure function of state and holds until rsp_ready is seen.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_q;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign is_idle    = (state_q == IDLE);
    assign req0_ready = is_idle && req0_valid && !grant;
    assign req1_ready = is_idle && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    // The high half of a chained op must consume the low-half carry/borrow.
    always_comb begin
        case (mode_q)
            3'd0:       hi_mode = 3'd2;
            3'd5, 3'd7: hi_mode = 3'd3;
            default:    hi_mode = mode_q;
        endcase
    end

    always_comb begin
        alu_mode  = {1'b0, mode_q};
        alu_isize = (size_q != 2'd0);
        alu_op1   = op1_q[15:0];
        alu_op2   = op2_q[15:0];
        alu_flags = cflags_q;
        if (state_q == HI) begin
            alu_mode  = {1'b0, hi_mode};
            alu_isize = 1'b1;
            alu_op1   = op1_q[31:16];
            alu_op2   = op2_q[31:16];
            alu_flags = {cflags_q[11:1], lo_flags_q[0]};
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        mode_d       = mode_q;
        size_d       = size_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        cflags_d     = cflags_q;
        lo_flags_d   = lo_flags_q;
        result_d     = result_q;
        rflags_d     = rflags_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d         = grant;
                    last_grant_d = grant;
                    mode_d       = grant ? req1_mode : req0_mode;
                    size_d       = grant ? req1_size : req0_size;
                    op1_d        = grant ? req1_op1  : req0_op1;
                    op2_d        = grant ? req1_op2  : req0_op2;
                    cflags_d     = flags_in;
                    state_d      = LO;
                end
            end
            LO: begin
                result_d   = {16'h0000, (size_q == 2'd0) ? {8'h00, alu_result[7:0]} : alu_result};
                lo_flags_d = alu_flags_o;
                if (size_q[1]) begin
                    state_d = HI;
                end else begin
                    rflags_d = alu_flags_o;
                    state_d  = RESP;
                end
            end
            HI: begin
                result_d[31:16] = alu_result;
                // OF/SF/CF describe the full word; ZF needs both halves zero; PF/AF live in the low byte.
                rflags_d = {alu_flags_o[11], cflags_q[10:8], alu_flags_o[7],
                            lo_flags_q[6] & alu_flags_o[6], alu_flags_o[5], lo_flags_q[4],
                            alu_flags_o[3], lo_flags_q[2], alu_flags_o[1:0]};
                state_d  = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            id_q         <= 1'b0;
            mode_q       <= 3'd0;
            size_q       <= 2'd0;
            op1_q        <= 32'd0;
            op2_q        <= 32'd0;
            cflags_q     <= 12'd0;
            lo_flags_q   <= 12'd0;
            result_q     <= 32'd0;
            rflags_q     <= 12'h002;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            mode_q       <= mode_d;
            size_q       <= size_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            cflags_q     <= cflags_d;
            lo_flags_q   <= lo_flags_d;
            result_q     <= result_d;
            rflags_q     <= rflags_d;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_flags  = rflags_q;
endmodule
